// File: rtl/time_set_controller.sv
// time_set_controller
// Front end of the six-digit 12-hour clock. It synchronises the pushbuttons,
// runs the reset/set/start mode machine and the hours/minutes/seconds edit
// cursor, and presets BCD time with per-field limits. In run mode it drives
// the free-running one-second counter, the tick pulse and the move-enable.
// Optional feature macro: TIME_SET_BLINK_EN adds a blink of the selected
// field while editing. When the macro is not defined, blankMask is tied to 0.
//
// Buttons are plain levels; an event is the first cycle a synchronised
// button is seen high, so holding a button gives exactly one event.
module time_set_controller #(
    parameter int TICK_MAX = 49999999,
    parameter int CNT_W    = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btnReset,
    input  logic             btnSet,
    input  logic             btnStart,
    input  logic             btnSelect,
    input  logic             btnUp,
    output logic [3:0]       state,
    output logic [23:0]      setBits,
    output logic [1:0]       cursor,
    output logic             canIMove,
    output logic [CNT_W-1:0] rCount,
    output logic             tick,
    output logic [5:0]       blankMask
);

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_SET   = 4'd1;
    localparam logic [3:0] S_START = 4'd3;

    localparam logic [23:0]      L_PRESET   = 24'h120000;
    localparam logic [CNT_W-1:0] L_TICK_MAX = CNT_W'(TICK_MAX);

    // Button order in every vector: reset, set, start, select, up.
    logic [4:0] w_btn;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] r_hist;
    logic [4:0] w_evt;

    logic [3:0]       r_state;
    logic [23:0]      r_set;
    logic [1:0]       r_cursor;
    logic [CNT_W-1:0] r_count;

    logic [3:0]  w_state_nxt;
    logic [23:0] w_set_nxt;
    logic [1:0]  w_cursor_nxt;

    // Seconds/minutes: 00..59, low nibble carries into high nibble.
    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Hours: 01..12, twelve wraps to one and zero is never produced.
    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h12) begin
            r = 8'h01;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign w_btn = {btnReset, btnSet, btnStart, btnSelect, btnUp};
    assign w_evt = r_sync2 & ~r_hist;

    // Two-flop synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Next mode, preset time and cursor; priority reset > start > set > select/up.
    always_comb begin
        w_state_nxt  = r_state;
        w_set_nxt    = r_set;
        w_cursor_nxt = r_cursor;
        if (w_evt[4]) begin
            w_state_nxt  = S_RESET;
            w_set_nxt    = L_PRESET;
            w_cursor_nxt = 2'd0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (w_evt[2]) begin
                        w_state_nxt = S_START;
                    end else if (w_evt[3]) begin
                        w_state_nxt = S_SET;
                    end
                end
                S_SET: begin
                    if (w_evt[2]) begin
                        w_state_nxt = S_START;
                    end else if (!w_evt[3]) begin
                        // Up edits the field under the old cursor even when
                        // select moves the cursor on the same edge.
                        if (w_evt[0]) begin
                            case (r_cursor)
                                2'd0:    w_set_nxt[7:0]   = inc_sixty(r_set[7:0]);
                                2'd1:    w_set_nxt[15:8]  = inc_sixty(r_set[15:8]);
                                2'd2:    w_set_nxt[23:16] = inc_hours(r_set[23:16]);
                                default: w_set_nxt        = r_set;
                            endcase
                        end
                        if (w_evt[1]) begin
                            w_cursor_nxt = (r_cursor == 2'd2) ? 2'd0 : r_cursor + 2'd1;
                        end
                    end
                end
                S_START: begin
                    w_state_nxt = S_START;
                end
                default: begin
                    w_state_nxt = S_RESET;
                end
            endcase
        end
    end

    // Mode, preset and cursor registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_RESET;
            r_set    <= L_PRESET;
            r_cursor <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_set    <= w_set_nxt;
            r_cursor <= w_cursor_nxt;
        end
    end

    // One-second counter: counts only while staying in run mode, so it reads
    // 0 on the first run cycle and drops to 0 on the edge that leaves run mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_state == S_START && w_state_nxt == S_START) begin
            r_count <= (r_count == L_TICK_MAX) ? '0 : r_count + CNT_W'(1);
        end else begin
            r_count <= '0;
        end
    end

    assign state    = r_state;
    assign setBits  = r_set;
    assign cursor   = r_cursor;
    assign rCount   = r_count;
    assign canIMove = (r_state == S_START);
    assign tick     = (r_state == S_START) && (r_count == L_TICK_MAX);

`ifdef TIME_SET_BLINK_EN
    localparam logic [CNT_W-1:0] L_HALF_M1 = CNT_W'((TICK_MAX + 1) / 2 - 1);

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;
    logic [5:0]       w_field_mask;

    // Blink timer: runs only while staying in set mode, phase flips each half period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_state == S_SET && w_state_nxt == S_SET) begin
            if (r_blink_cnt == L_HALF_M1) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CNT_W'(1);
            end
        end else begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end
    end

    // Digit pair belonging to the field under the cursor.
    always_comb begin
        w_field_mask = 6'b000000;
        case (r_cursor)
            2'd0:    w_field_mask = 6'b000011;
            2'd1:    w_field_mask = 6'b001100;
            2'd2:    w_field_mask = 6'b110000;
            default: w_field_mask = 6'b000000;
        endcase
    end

    assign blankMask = r_blink_phase ? w_field_mask : 6'b000000;
`else
    assign blankMask = 6'b000000;
`endif

endmodule
